// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS-subset ID stage: opcodes, funct codes,
// ALU operation encodings and the bit layout of the control bundle.
package mips_pkg;

   localparam int CTRL_W = 10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [3:0] {
      ALU_NONE = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_LINK = 4'd6
   } alu_op_t;

   localparam int CTRL_REG_WRITE  = 9;
   localparam int CTRL_MEM_READ   = 8;
   localparam int CTRL_MEM_WRITE  = 7;
   localparam int CTRL_MEM_TO_REG = 6;
   localparam int CTRL_ALU_SRC    = 5;
   localparam int CTRL_REG_DST    = 4;
   localparam int CTRL_ALU_MSB    = 3;
   localparam int CTRL_ALU_LSB    = 0;

   function automatic logic [CTRL_W-1:0] mk_ctrl(input logic rw, input logic mr,
                                                 input logic mw, input logic m2r,
                                                 input logic src, input logic dst,
                                                 input alu_op_t alu);
      logic [CTRL_W-1:0] c;
      c = '0;
      c[CTRL_REG_WRITE]  = rw;
      c[CTRL_MEM_READ]   = mr;
      c[CTRL_MEM_WRITE]  = mw;
      c[CTRL_MEM_TO_REG] = m2r;
      c[CTRL_ALU_SRC]    = src;
      c[CTRL_REG_DST]    = dst;
      c[CTRL_ALU_MSB:CTRL_ALU_LSB] = alu;
      return c;
   endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file, two combinational reads and one posedge write.
// Entry 0 is hardwired to zero. Build with DECODE_BYPASS_EN to forward same-cycle writeback.
module register_file #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               we,
   input  logic [NB_ADDR-1:0] wr_addr,
   input  logic [NB_REG-1:0]  wr_data,
   input  logic [NB_ADDR-1:0] rd_addr_a,
   input  logic [NB_ADDR-1:0] rd_addr_b,
   output logic [NB_REG-1:0]  rd_data_a,
   output logic [NB_REG-1:0]  rd_data_b
);

   localparam int N_ENTRIES = 2**NB_ADDR;

   logic [NB_REG-1:0] regs [N_ENTRIES];
   logic              wr_ok;

   assign wr_ok = we && (wr_addr != '0);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < N_ENTRIES; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
      rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef DECODE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      if (wr_ok && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
   end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: IF/ID register, decode, load-use stall, early branch/jump redirect and ID/EX register.
// DECODE_BYPASS_EN (in register_file) selects writeback-to-read forwarding.
module instruction_decode
   import mips_pkg::*;
#(
   parameter int NB_REG   = 32,
   parameter int NB_INSTR = 32,
   parameter int NB_ADDR  = 5,
   parameter int NB_INM_I = 16,
   parameter int NB_INM_J = 26,
   parameter int NB_CTRL  = 10
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [NB_INSTR-1:0] i_instruction,
   input  logic [NB_REG-1:0]   i_pc,
   input  logic                i_wb_we,
   input  logic [NB_ADDR-1:0]  i_wb_addr,
   input  logic [NB_REG-1:0]   i_wb_data,
   input  logic                i_ex_mem_read,
   input  logic [NB_ADDR-1:0]  i_ex_rt,
   output logic [NB_REG-1:0]   o_rs_data,
   output logic [NB_REG-1:0]   o_rt_data,
   output logic [NB_REG-1:0]   o_inm_ext,
   output logic [NB_REG-1:0]   o_pc,
   output logic [NB_ADDR-1:0]  o_rt_addr,
   output logic [NB_ADDR-1:0]  o_rd_addr,
   output logic [NB_CTRL-1:0]  o_ctrl,
   output logic                o_branch,
   output logic                o_jump_inm,
   output logic                o_jump_rs,
   output logic [NB_INM_I-1:0] o_inm_i,
   output logic [NB_INM_J-1:0] o_inm_j,
   output logic [NB_REG-1:0]   o_rs,
   output logic                o_nop_reg,
   output logic                o_stall
);

   logic [NB_INSTR-1:0] if_instr;
   logic [NB_REG-1:0]   if_pc;
   logic                nop_q;

   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic [NB_ADDR-1:0]  rs_addr;
   logic [NB_ADDR-1:0]  rt_addr;
   logic [NB_ADDR-1:0]  dec_rd;
   logic [NB_REG-1:0]   rs_data;
   logic [NB_REG-1:0]   rt_data;
   logic [NB_REG-1:0]   inm_ext;
   logic [CTRL_W-1:0]   dec_ctrl;
   logic                reads_rt;
   logic                zero_ext;
   logic                stall;
   logic                advance;
   logic                redirect;

   assign opcode  = if_instr[31:26];
   assign funct   = if_instr[5:0];
   assign rs_addr = if_instr[25:21];
   assign rt_addr = if_instr[20:16];

   register_file #(
      .NB_REG  (NB_REG),
      .NB_ADDR (NB_ADDR)
   ) u_register_file (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .we        (i_wb_we & i_valid),
      .wr_addr   (i_wb_addr),
      .wr_data   (i_wb_data),
      .rd_addr_a (rs_addr),
      .rd_addr_b (rt_addr),
      .rd_data_a (rs_data),
      .rd_data_b (rt_data)
   );

   // Branches and plain jumps resolve here, so they carry no EX work; links write rd / $31.
   always_comb begin
      dec_ctrl = '0;
      reads_rt = 1'b0;
      zero_ext = 1'b0;
      dec_rd   = if_instr[15:11];
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);  reads_rt = 1'b1; end
               FN_SUB:  begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB);  reads_rt = 1'b1; end
               FN_AND:  begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND);  reads_rt = 1'b1; end
               FN_OR:   begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);   reads_rt = 1'b1; end
               FN_SLT:  begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT);  reads_rt = 1'b1; end
               FN_JALR: dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_LINK);
               default: ;
            endcase
         end
         OP_ADDI: dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
         OP_ANDI: begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_AND); zero_ext = 1'b1; end
         OP_ORI:  begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OR);  zero_ext = 1'b1; end
         OP_LW:   dec_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
         OP_SW:   begin dec_ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD); reads_rt = 1'b1; end
         OP_BEQ,
         OP_BNE:  reads_rt = 1'b1;
         OP_JAL:  begin dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_LINK); dec_rd = '1; end
         default: ;
      endcase
   end

   assign inm_ext = {{(NB_REG-NB_INM_I){zero_ext ? 1'b0 : if_instr[NB_INM_I-1]}},
                     if_instr[NB_INM_I-1:0]};

   assign stall = i_ex_mem_read && (i_ex_rt != '0) &&
                  ((i_ex_rt == rs_addr) || (reads_rt && (i_ex_rt == rt_addr)));

   assign advance    = i_valid && !stall;
   assign o_branch   = advance && (((opcode == OP_BEQ) && (rs_data == rt_data)) ||
                                   ((opcode == OP_BNE) && (rs_data != rt_data)));
   assign o_jump_inm = advance && ((opcode == OP_J) || (opcode == OP_JAL));
   assign o_jump_rs  = advance && (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
   assign redirect   = o_branch || o_jump_inm || o_jump_rs;

   assign o_stall   = stall;
   assign o_rs      = rs_data;
   assign o_inm_i   = if_instr[NB_INM_I-1:0];
   assign o_inm_j   = if_instr[NB_INM_J-1:0];
   assign o_nop_reg = nop_q;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         if_instr <= '0;
         if_pc    <= '0;
         nop_q    <= 1'b0;
      end else if (i_valid) begin
         nop_q <= redirect;
         if (redirect) begin
            if_instr <= '0;
            if_pc    <= '0;
         end else if (!stall) begin
            if_instr <= i_instruction;
            if_pc    <= i_pc;
         end
      end
   end

   // A stall issues a fully cleared bubble into EX.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_rs_data <= '0;
         o_rt_data <= '0;
         o_inm_ext <= '0;
         o_pc      <= '0;
         o_rt_addr <= '0;
         o_rd_addr <= '0;
         o_ctrl    <= '0;
      end else if (i_valid) begin
         if (stall) begin
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_inm_ext <= '0;
            o_pc      <= '0;
            o_rt_addr <= '0;
            o_rd_addr <= '0;
            o_ctrl    <= '0;
         end else begin
            o_rs_data <= rs_data;
            o_rt_data <= rt_data;
            o_inm_ext <= inm_ext;
            o_pc      <= if_pc;
            o_rt_addr <= rt_addr;
            o_rd_addr <= dec_rd;
            o_ctrl    <= dec_ctrl;
         end
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed + randomized bench for instruction_decode with a cycle-level reference model.
`timescale 1ns/1ps
module tb_instruction_decode;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic [31:0] i_instruction;
   logic [31:0] i_pc;
   logic        i_wb_we;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        i_ex_mem_read;
   logic [4:0]  i_ex_rt;
   logic [31:0] o_rs_data, o_rt_data, o_inm_ext, o_pc, o_rs;
   logic [4:0]  o_rt_addr, o_rd_addr;
   logic [9:0]  o_ctrl;
   logic        o_branch, o_jump_inm, o_jump_rs, o_nop_reg, o_stall;
   logic [15:0] o_inm_i;
   logic [25:0] o_inm_j;

   int checks   = 0;
   int failures = 0;

   always #5 i_clock = ~i_clock;

   instruction_decode dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
      .i_instruction(i_instruction), .i_pc(i_pc),
      .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
      .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_inm_ext(o_inm_ext), .o_pc(o_pc),
      .o_rt_addr(o_rt_addr), .o_rd_addr(o_rd_addr), .o_ctrl(o_ctrl),
      .o_branch(o_branch), .o_jump_inm(o_jump_inm), .o_jump_rs(o_jump_rs),
      .o_inm_i(o_inm_i), .o_inm_j(o_inm_j), .o_rs(o_rs),
      .o_nop_reg(o_nop_reg), .o_stall(o_stall)
   );

   // Reference model state: architectural registers, fetched instruction, EX-bound bundle.
   logic [31:0] m_rf [32];
   logic [31:0] m_if_instr, m_if_pc;
   logic        m_nop;
   logic [31:0] m_rs_data, m_rt_data, m_inm, m_pc;
   logic [4:0]  m_rt_addr, m_rd_addr;
   logic [9:0]  m_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] ADD3  = {6'd0, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20};
   localparam logic [31:0] ADD6  = {6'd0, 5'd4, 5'd1, 5'd6, 5'd0, 6'h20};
   localparam logic [31:0] BEQ12 = {6'h04, 5'd1, 5'd2, 16'h0004};
   localparam logic [31:0] LW4   = {6'h23, 5'd1, 5'd4, 16'h0000};
   localparam logic [31:0] ADDI9 = {6'h08, 5'd9, 5'd10, 16'h0001};
   localparam logic [9:0]  CTRL_ADD_R = 10'b1000010001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ref_ctrl(input logic [31:0] ins);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         case (fn)
            6'h20: return 10'b1000010001;
            6'h22: return 10'b1000010010;
            6'h24: return 10'b1000010011;
            6'h25: return 10'b1000010100;
            6'h2A: return 10'b1000010101;
            6'h09: return 10'b1000010110;
            default: return 10'b0;
         endcase
      end
      case (op)
         6'h08: return 10'b1000100001;
         6'h0C: return 10'b1000100011;
         6'h0D: return 10'b1000100100;
         6'h23: return 10'b1101100001;
         6'h2B: return 10'b0010100001;
         6'h03: return 10'b1000010110;
         default: return 10'b0;
      endcase
   endfunction

   function automatic bit ref_reads_rt(input logic [31:0] ins);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
      return (op == 6'h2B || op == 6'h04 || op == 6'h05);
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      logic [31:0] v;
      v = (idx == 5'd0) ? 32'd0 : m_rf[idx];
`ifdef DECODE_BYPASS_EN
      if (i_valid && i_wb_we && i_wb_addr != 5'd0 && i_wb_addr == idx) v = i_wb_data;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_if_instr = '0; m_if_pc = '0; m_nop = 1'b0;
      m_rs_data = '0; m_rt_data = '0; m_inm = '0; m_pc = '0;
      m_rt_addr = '0; m_rd_addr = '0; m_ctrl = '0;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic exr, input logic [4:0] ext);
      i_valid = v; i_instruction = ins; i_pc = pc;
      i_wb_we = we; i_wb_addr = wa; i_wb_data = wd;
      i_ex_mem_read = exr; i_ex_rt = ext;
   endtask

   // Called shortly after a negedge with inputs driven; compares, crosses one posedge, returns at negedge.
   task automatic step();
      logic [4:0]  rs, rt, rd;
      logic [5:0]  op, fn;
      logic [31:0] rs_v, rt_v, imm;
      logic        stl, adv, br, ji, jr, redir;
      int          n_strobe;
      #2;
      op = m_if_instr[31:26]; fn = m_if_instr[5:0];
      rs = m_if_instr[25:21]; rt = m_if_instr[20:16];
      rd = (op == 6'h03) ? 5'd31 : m_if_instr[15:11];
      rs_v = ref_read(rs); rt_v = ref_read(rt);
      imm = (op == 6'h0C || op == 6'h0D) ? {16'h0, m_if_instr[15:0]}
                                         : {{16{m_if_instr[15]}}, m_if_instr[15:0]};
      stl = i_ex_mem_read && i_ex_rt != 0 &&
            (i_ex_rt == rs || (ref_reads_rt(m_if_instr) && i_ex_rt == rt));
      adv = i_valid && !stl;
      br  = adv && ((op == 6'h04 && rs_v == rt_v) || (op == 6'h05 && rs_v != rt_v));
      ji  = adv && (op == 6'h02 || op == 6'h03);
      jr  = adv && op == 6'h00 && (fn == 6'h08 || fn == 6'h09);
      redir = br || ji || jr;

      chk("stall", {31'd0, o_stall}, {31'd0, stl});
      chk("branch", {31'd0, o_branch}, {31'd0, br});
      chk("jump_inm", {31'd0, o_jump_inm}, {31'd0, ji});
      chk("jump_rs", {31'd0, o_jump_rs}, {31'd0, jr});
      n_strobe = int'(o_branch) + int'(o_jump_inm) + int'(o_jump_rs);
      chk("strobe_onehot", {31'd0, n_strobe > 1}, 32'd0);
      chk("rs_fetch", o_rs, rs_v);
      chk("inm_i", {16'd0, o_inm_i}, {16'd0, m_if_instr[15:0]});
      chk("inm_j", {6'd0, o_inm_j}, {6'd0, m_if_instr[25:0]});
      chk("nop_reg", {31'd0, o_nop_reg}, {31'd0, m_nop});
      chk("rs_data", o_rs_data, m_rs_data);
      chk("rt_data", o_rt_data, m_rt_data);
      chk("inm_ext", o_inm_ext, m_inm);
      chk("pc", o_pc, m_pc);
      chk("rt_addr", {27'd0, o_rt_addr}, {27'd0, m_rt_addr});
      chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, m_rd_addr});
      chk("ctrl", {22'd0, o_ctrl}, {22'd0, m_ctrl});

      @(posedge i_clock);
      if (i_valid) begin
         if (stl) begin
            m_rs_data = '0; m_rt_data = '0; m_inm = '0; m_pc = '0;
            m_rt_addr = '0; m_rd_addr = '0; m_ctrl = '0;
         end else begin
            m_rs_data = rs_v; m_rt_data = rt_v; m_inm = imm; m_pc = m_if_pc;
            m_rt_addr = rt; m_rd_addr = rd; m_ctrl = ref_ctrl(m_if_instr);
         end
         m_nop = redir;
         if (redir) begin
            m_if_instr = '0; m_if_pc = '0;
         end else if (!stl) begin
            m_if_instr = i_instruction; m_if_pc = i_pc;
         end
         if (i_wb_we && i_wb_addr != 0) m_rf[i_wb_addr] = i_wb_data;
      end
      @(negedge i_clock);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rs_data"}, o_rs_data, 32'd0);
      chk({tag, "_rt_data"}, o_rt_data, 32'd0);
      chk({tag, "_inm_ext"}, o_inm_ext, 32'd0);
      chk({tag, "_pc"}, o_pc, 32'd0);
      chk({tag, "_addrs"}, {22'd0, o_rt_addr, o_rd_addr}, 32'd0);
      chk({tag, "_ctrl"}, {22'd0, o_ctrl}, 32'd0);
      chk({tag, "_strobes"}, {27'd0, o_branch, o_jump_inm, o_jump_rs, o_nop_reg, o_stall}, 32'd0);
      chk({tag, "_rs"}, o_rs, 32'd0);
      chk({tag, "_inm"}, {6'd0, o_inm_j}, 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 17))
         0:  return {6'd0, rs, rt, rd, 5'd0, 6'h20};
         1:  return {6'd0, rs, rt, rd, 5'd0, 6'h22};
         2:  return {6'd0, rs, rt, rd, 5'd0, 6'h24};
         3:  return {6'd0, rs, rt, rd, 5'd0, 6'h25};
         4:  return {6'd0, rs, rt, rd, 5'd0, 6'h2A};
         5:  return {6'd0, rs, 5'd0, 5'd0, 5'd0, 6'h08};
         6:  return {6'd0, rs, 5'd0, rd, 5'd0, 6'h09};
         7:  return {6'h08, rs, rt, imm};
         8:  return {6'h0C, rs, rt, imm};
         9:  return {6'h0D, rs, rt, imm};
         10: return {6'h23, rs, rt, imm};
         11: return {6'h2B, rs, rt, imm};
         12: return {6'h04, rs, rt, imm};
         13: return {6'h05, rs, rt, imm};
         14: return {6'h02, 26'($urandom)};
         15: return {6'h03, 26'($urandom)};
         16: return {6'h3F, rs, rt, imm};
         default: return NOP;
      endcase
   endfunction

   initial begin
      drive(1'b0, NOP, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      i_reset = 1'b0;
      model_reset();
      #3;
      chk_all_zero("reset");
      @(negedge i_clock);
      i_reset = 1'b1;

      // Writeback R5 then ADD $3,$5,$0
      drive(1'b1, ADD3, 32'h100, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0); step();
      drive(1'b1, NOP, 32'h104, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
      chk("s1_rs_data", o_rs_data, 32'h0000_00AA);
      chk("s1_reg_write", {31'd0, o_ctrl[9]}, 32'd1);
      chk("s1_rd_addr", {27'd0, o_rd_addr}, 32'd3);

      // BEQ taken with R1 == R2 == 7
      drive(1'b1, NOP, 32'h108, 1'b1, 5'd1, 32'd7, 1'b0, 5'd0); step();
      drive(1'b1, NOP, 32'h10C, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0); step();
      drive(1'b1, BEQ12, 32'h110, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
      drive(1'b1, ADD3, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 chk("s2_branch", {31'd0, o_branch}, 32'd1);
      step();
      chk("s2_nop_reg", {31'd0, o_nop_reg}, 32'd1);
      chk("s2_ctrl", {22'd0, o_ctrl}, 32'd0);

      // Load-use: LW $4 in EX, ADD $6,$4,$1 in IF/ID
      drive(1'b1, LW4, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
      drive(1'b1, ADD6, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
      drive(1'b1, NOP, 32'h208, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
      #1 chk("s3_stall", {31'd0, o_stall}, 32'd1);
      step();
      drive(1'b1, NOP, 32'h208, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 chk("s3_stall_release", {31'd0, o_stall}, 32'd0);
      chk("s3_bubble", {22'd0, o_ctrl}, 32'd0);
      step();
      chk("s3_add_ctrl", {22'd0, o_ctrl}, {22'd0, CTRL_ADD_R});
      chk("s3_add_rd", {27'd0, o_rd_addr}, 32'd6);

      // Same-cycle writeback to a register being read
      drive(1'b1, ADDI9, 32'h300, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 5'd0); step();
      drive(1'b1, NOP, 32'h304, 1'b1, 5'd9, 32'h0000_1234, 1'b0, 5'd0);
`ifdef DECODE_BYPASS_EN
      #1 chk("s4_bypass_rs", o_rs, 32'h0000_1234);
      step();
      chk("s4_bypass_idex", o_rs_data, 32'h0000_1234);
`else
      #1 chk("s4_old_rs", o_rs, 32'h0000_0055);
      step();
      chk("s4_old_idex", o_rs_data, 32'h0000_0055);
`endif

      // R0 stays zero
      drive(1'b1, NOP, 32'h308, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
      #1 chk("s5_r0_same_cycle", o_rs, 32'd0);
      step();
      drive(1'b1, NOP, 32'h30C, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 chk("s5_r0_read", o_rs, 32'd0);
      step();

      // Reset asserted in the middle of a stall
      drive(1'b1, ADD6, 32'h400, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
      drive(1'b1, ADD3, 32'h404, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
      #1 chk("s6_stall", {31'd0, o_stall}, 32'd1);
      #1 i_reset = 1'b0;
      #1 chk_all_zero("s6_reset");
      model_reset();
      @(negedge i_clock);
      i_reset = 1'b1;
      drive(1'b1, ADD3, 32'h500, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
      chk("s6_first_nop_ctrl", {22'd0, o_ctrl}, 32'd0);
      chk("s6_first_nop_rd", {27'd0, o_rd_addr}, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 7) != 0), rand_instr(), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameters SHALL be NB_REG = 32 (datapath width), NB_INSTR = 32 (instruction width), NB_ADDR = 5 (register index width), NB_INM_I = 16 (I-type immediate width), NB_INM_J = 26 (J-type target width), NB_CTRL = 10 (control bundle width).
REQ-002 Ports SHALL be, in order:
- i_clock  in  1  single clock, posedge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  global advance enable.
- i_instruction  in  NB_INSTR  instruction from fetch.
- i_pc  in  NB_REG  PC of that instruction.
- i_wb_we / i_wb_addr / i_wb_data  in  1 / NB_ADDR / NB_REG  writeback port.
- i_ex_mem_read / i_ex_rt  in  1 / NB_ADDR  EX-stage load and its destination.
- o_rs_data, o_rt_data, o_inm_ext, o_pc  out  NB_REG  ID/EX operands.
- o_rt_addr, o_rd_addr  out  NB_ADDR.
- o_ctrl  out  NB_CTRL  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]}.
- o_branch, o_jump_inm, o_jump_rs  out  1  redirect strobes to fetch.
- o_inm_i  out  NB_INM_I.
- o_inm_j  out  NB_INM_J.
- o_rs  out  NB_REG  jump/branch operands to fetch.
- o_nop_reg  out  1  squash flag to fetch.
- o_stall  out  1  freeze fetch.

Function
REQ-003 The IF/ID register SHALL capture i_instruction and i_pc on posedge when i_valid=1 and o_stall=0, and SHALL hold when o_stall=1.
REQ-004 The register file SHALL hold 32 x NB_REG entries, provide two combinational reads (rs=instr[25:21], rt=instr[20:16]) and one posedge write; index 0 SHALL read 0, and writes to index 0 SHALL be ignored.
REQ-005 Decode SHALL cover the R-type ops (funct ADD, SUB, AND, OR, SLT, JR, JALR) plus ADDI, ANDI, ORI, LW, SW, BEQ, BNE, J and JAL; unknown opcodes SHALL decode to all-zero o_ctrl.
REQ-006 o_inm_ext SHALL be instr[15:0] zero-extended for ANDI/ORI and sign-extended otherwise.
REQ-007 The ID/EX outputs (o_rs_data, o_rt_data, o_inm_ext, o_pc, o_rt_addr, o_rd_addr, o_ctrl) SHALL be registered, giving 1-cycle latency from IF/ID to ID/EX, and SHALL update only when i_valid=1.
REQ-008 The redirect strobes SHALL be combinational from IF/ID, with each strobe gated by i_valid and by !o_stall:
- o_branch = (BEQ and rs==rt) or (BNE and rs!=rt).
- o_jump_inm = J or JAL.
- o_jump_rs = JR or JALR.
REQ-009 At most one redirect strobe SHALL be high in any cycle.
REQ-010 On a redirect edge, o_nop_reg SHALL be set to 1 for exactly one valid cycle and the IF/ID register SHALL load all-zero (NOP).
REQ-011 Load-use hazard: when i_ex_mem_read=1, i_ex_rt!=0 and i_ex_rt equals IF/ID rs, or equals IF/ID rt for an instruction that reads rt, o_stall SHALL be 1 combinationally and ID/EX SHALL load a bubble (o_ctrl=0).
REQ-012 When a stall and a redirect coincide, the stall SHALL win and the redirect SHALL be re-evaluated in the next cycle.
REQ-013 When i_valid=0, all state SHALL hold and no strobe SHALL assert.

Reset
REQ-014 i_reset=0 SHALL immediately and asynchronously clear the IF/ID register, the ID/EX register, o_nop_reg and all 32 register-file entries to 0, including when asserted mid-stall or mid-redirect.
REQ-015 On the first valid edge after reset release, the block SHALL decode a NOP.

Configuration
REQ-016 With macro DECODE_BYPASS_EN defined, a read whose index equals a same-cycle writeback address (i_wb_we=1, address nonzero) SHALL return i_wb_data.
REQ-017 Without DECODE_BYPASS_EN, such a read SHALL return the pre-write register value.

Structure
REQ-018 Opcode constants, funct constants, alu_op encodings and the o_ctrl bit positions SHALL live in the shared package mips_pkg.
REQ-019 The register file SHALL be a separate sub-module, register_file, which contains the DECODE_BYPASS_EN logic.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write R5=0x0000_00AA via WB, then decode ADD $3,$5,$0 -> next cycle o_rs_data=0xAA, o_ctrl.reg_write=1, o_rd_addr=3.
- BEQ $1,$2 with R1=R2=7, imm=0x0004 -> o_branch=1 in the same cycle; next cycle o_nop_reg=1 and o_ctrl=0.
- Decode LW to rt=4 while EX has i_ex_mem_read=1, i_ex_rt=4, and IF/ID holds ADD $6,$4,$1 -> o_stall=1 for one cycle, bubble issued, ADD then proceeds.
- WB writes R9=0x1234 while reading R9 in the same cycle -> 0x1234 with DECODE_BYPASS_EN, old value without.
- Write R0=0xFFFF_FFFF, then read R0 -> 0.
- Reset asserted mid-stall -> all outputs 0 immediately; first valid edge after release decodes a NOP.
